// File: rtl/vsc8541_smi_ctrl.sv
// VSC8541 SMI command sequencer: READ/WRITE/RMW commands in, one or two
// MDIO frames out via the frame engine, timed by MDC falling edges.
module vsc8541_smi_ctrl #(
  parameter int STARTUP_EDGES = 6,
  parameter int FRAME_EDGES   = 33
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_mdc,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_phy,
  input  logic [4:0]  i_cmd_reg,
  input  logic [15:0] i_cmd_data,
  input  logic [15:0] i_cmd_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_smi_mode,
  output logic        o_smi_en,
  output logic [4:0]  o_smi_phy_addr,
  output logic [4:0]  o_smi_reg_addr,
  output logic [15:0] o_smi_data,
  input  logic        i_smi_dv,
  input  logic [15:0] i_smi_data
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  localparam logic [5:0] SU_LAST = 6'(STARTUP_EDGES - 1);
  localparam logic [5:0] FR_LAST = 6'(FRAME_EDGES - 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        prev_mdc;
  logic        fall;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic [15:0] mask_q, mask_d;
  logic        phase_q, phase_d;
  logic        mode_q, mode_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdat_q, rdat_d;
  logic        err_q, err_d;
  logic [15:0] merged;

  // Engine data-valid fires before the last read bit, so timing uses MDC only.
  logic unused_dv;
  assign unused_dv = i_smi_dv;

  assign fall   = prev_mdc & ~i_mdc;
  assign merged = (i_smi_data & ~mask_q) | (data_q & mask_q);

  assign o_cmd_ready    = (state_q == ST_IDLE);
  assign o_smi_en       = (state_q == ST_LAUNCH);
  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_smi_mode     = mode_q;
  assign o_smi_phy_addr = phy_q;
  assign o_smi_reg_addr = reg_q;
  assign o_smi_data     = wdat_q;
  assign o_rsp_data     = rdat_q;
  assign o_rsp_err      = err_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    unique case (state_q)
      ST_STARTUP: begin
        if (fall) begin
          if (cnt_q == SU_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_IDLE: begin
        if (i_cmd_valid) begin
          op_d   = i_cmd_op;
          phy_d  = i_cmd_phy;
          reg_d  = i_cmd_reg;
          data_d = i_cmd_data;
          mask_d = i_cmd_mask;
          cnt_d  = '0;
          err_d  = 1'b0;
          unique case (1'b1)
            (i_cmd_op == OP_READ),
            (i_cmd_op == OP_RMW): begin
              mode_d  = 1'b0;
              phase_d = 1'b0;
              state_d = ST_LAUNCH;
            end
            (i_cmd_op == OP_WRITE): begin
              mode_d  = 1'b1;
              wdat_d  = i_cmd_data;
              phase_d = 1'b1;
              state_d = ST_LAUNCH;
            end
            default: begin
              err_d   = 1'b1;
              rdat_d  = '0;
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fall) begin
          if (cnt_q == FR_LAST) begin
            cnt_d = '0;
            if (!phase_q) begin
              if (op_q == OP_RMW) begin
                wdat_d  = merged;
                rdat_d  = merged;
                mode_d  = 1'b1;
                phase_d = 1'b1;
                state_d = ST_LAUNCH;
              end else begin
                rdat_d  = i_smi_data;
                state_d = ST_RESP;
              end
            end else begin
              if (op_q == OP_WRITE) rdat_d = wdat_q;
              state_d = ST_RESP;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // State, edge detector and datapath registers.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= ST_STARTUP;
      prev_mdc <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      phase_q  <= 1'b0;
      mode_q   <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_mdc <= i_mdc;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      phy_q    <= phy_d;
      reg_q    <= reg_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      err_q    <= err_d;
    end
  end

endmodule
